// File: rtl/poly_tone_mixer_if.sv
// Control/status bundle between a music streamer and poly_tone_mixer.
// The master drives voice configuration; the slave returns the PWM bit and voice status.
interface poly_tone_mixer_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned VOL_W    = 3
);
    logic                         output_enable;
    logic [NUM_CH-1:0]            ch_enable;
    logic [NUM_CH*PERIOD_W-1:0]   tone_period;
    logic [VOL_W-1:0]             volume;
    logic                         square_wave_out;
    logic [NUM_CH-1:0]            ch_active;

    modport master (
        output output_enable, ch_enable, tone_period, volume,
        input  square_wave_out, ch_active
    );

    modport slave (
        input  output_enable, ch_enable, tone_period, volume,
        output square_wave_out, ch_active
    );
endinterface

// File: rtl/poly_tone_mixer.sv
// NUM_CH square-wave voices summed, volume-scaled and rendered as a single PWM audio bit.
// Each voice adopts a new half-period only at its wrap edge so pitch changes never glitch.
module poly_tone_mixer #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned VOL_W    = 3,
    parameter int unsigned PWM_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    poly_tone_mixer_if.slave   bus
);
    localparam int unsigned LVL_W  = $clog2(NUM_CH + 1);
    localparam int unsigned DUTY_W = PWM_W + 1;
    localparam int unsigned STEP   = (2 ** PWM_W) / NUM_CH;
    localparam logic [VOL_W-1:0] MAXV     = '1;
    localparam logic [PWM_W-1:0] PWM_LAST = '1;

    logic [NUM_CH-1:0][PERIOD_W-1:0] r_cnt;
    logic [NUM_CH-1:0][PERIOD_W-1:0] r_shadow;
    logic [NUM_CH-1:0]               r_sq;
    logic [NUM_CH-1:0]               r_ch_active;
    logic [PWM_W-1:0]                r_pwm_cnt;
    logic [DUTY_W-1:0]               r_duty_q;
    logic                            r_out;

    logic [NUM_CH-1:0][PERIOD_W-1:0] w_cnt_nxt;
    logic [NUM_CH-1:0][PERIOD_W-1:0] w_shadow_nxt;
    logic [NUM_CH-1:0]               w_sq_nxt;
    logic [NUM_CH-1:0]               w_active_nxt;
    logic [PERIOD_W-1:0]             w_per;
    logic [LVL_W-1:0]                w_level;
    logic [DUTY_W-1:0]               w_raw;
    logic [DUTY_W-1:0]               w_duty;

    // Per-voice next state: disable dominates, idle voices load immediately, running voices reload at wrap
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_sq_nxt     = r_sq;
        w_active_nxt = '0;
        w_per        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_per = bus.tone_period[i*PERIOD_W +: PERIOD_W];
            if (!bus.ch_enable[i]) begin
                w_cnt_nxt[i]    = '0;
                w_shadow_nxt[i] = '0;
                w_sq_nxt[i]     = 1'b0;
            end else if (r_shadow[i] == '0) begin
                w_cnt_nxt[i]    = '0;
                w_shadow_nxt[i] = w_per;
                w_sq_nxt[i]     = 1'b0;
            end else if (r_cnt[i] == r_shadow[i] - PERIOD_W'(1)) begin
                w_cnt_nxt[i]    = '0;
                w_shadow_nxt[i] = w_per;
                w_sq_nxt[i]     = (w_per != '0) ? ~r_sq[i] : 1'b0;
            end else begin
                w_cnt_nxt[i]    = r_cnt[i] + PERIOD_W'(1);
            end
            w_active_nxt[i] = (w_shadow_nxt[i] != '0);
        end
    end

    // Mixer: count high voices, scale to carrier range, attenuate by volume
    always_comb begin
        w_level = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_level = w_level + LVL_W'(r_sq[i]);
        end
        w_raw  = DUTY_W'(w_level) * DUTY_W'(STEP);
        w_duty = w_raw >> (MAXV - bus.volume);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_sq        <= '0;
            r_ch_active <= '0;
            r_pwm_cnt   <= '0;
            r_duty_q    <= '0;
            r_out       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_sq        <= w_sq_nxt;
            r_ch_active <= w_active_nxt;
            r_pwm_cnt   <= r_pwm_cnt + PWM_W'(1);
            // Duty is latched only at the carrier boundary so each carrier period is uniform
            if (r_pwm_cnt == PWM_LAST) begin
                r_duty_q <= w_duty;
            end
            r_out       <= bus.output_enable & ({1'b0, r_pwm_cnt} < r_duty_q);
        end
    end

    assign bus.square_wave_out = r_out;
    assign bus.ch_active       = r_ch_active;
endmodule

// File: tb/tb_poly_tone_mixer.sv
// Directed bench for poly_tone_mixer with NUM_CH=2, PERIOD_W=8, PWM_W=4, VOL_W=3.
module tb_poly_tone_mixer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    poly_tone_mixer_if #(.NUM_CH(2), .PERIOD_W(8), .VOL_W(3)) bus ();

    poly_tone_mixer #(.NUM_CH(2), .PERIOD_W(8), .VOL_W(3), .PWM_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0] en;
        logic [2:0] vol;
        int         duty;
    } vec_t;

    vec_t vecs [10];
    int   n_pass  = 0;
    int   n_total = 0;
    int   tog [7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_high(output int c);
        c = 0;
        repeat (16) begin
            step();
            c += int'(bus.square_wave_out);
        end
    endtask

    task automatic wait_pwm(input int target);
        int k;
        k = 0;
        while (int'(dut.r_pwm_cnt) != target && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) check("pwm_sync_timeout", int'(dut.r_pwm_cnt), target);
    endtask

    function automatic int exp_sq(input int n);
        int t;
        t = 0;
        for (int j = 0; j < 7; j++) if (tog[j] <= n) t++;
        return t % 2;
    endfunction

    initial begin
        int cur_en;
        int c;
        int p0;
        int pre;

        // Expected duty: level 2 raw=16, level 1 raw=8, shifted right by 7-volume
        vecs[0] = '{en: 2'b11, vol: 3'd7, duty: 16};
        vecs[1] = '{en: 2'b11, vol: 3'd6, duty: 8};
        vecs[2] = '{en: 2'b11, vol: 3'd5, duty: 4};
        vecs[3] = '{en: 2'b11, vol: 3'd4, duty: 2};
        vecs[4] = '{en: 2'b11, vol: 3'd3, duty: 1};
        vecs[5] = '{en: 2'b11, vol: 3'd0, duty: 0};
        vecs[6] = '{en: 2'b01, vol: 3'd5, duty: 2};
        vecs[7] = '{en: 2'b01, vol: 3'd4, duty: 1};
        vecs[8] = '{en: 2'b01, vol: 3'd3, duty: 0};
        vecs[9] = '{en: 2'b01, vol: 3'd7, duty: 8};
        // Voice 0 toggle edges: period 5 until the change, then 3 after the wrap at edge 21
        tog = '{6, 11, 16, 21, 24, 27, 30};

        rst = 1'b1;
        bus.output_enable = 1'b1;
        bus.ch_enable     = 2'b00;
        bus.tone_period   = '0;
        bus.volume        = 3'd7;
        repeat (2) @(negedge clk);
        check("reset_out", int'(bus.square_wave_out), 0);
        check("reset_ch_active", int'(bus.ch_active), 0);
        check("reset_duty_q", int'(dut.r_duty_q), 0);

        // Voice 0 start at period 5, then mid-cycle change to 3
        rst = 1'b0;
        bus.ch_enable = 2'b01;
        bus.tone_period[7:0] = 8'd5;
        for (int n = 1; n <= 30; n++) begin
            step();
            check($sformatf("sq0_edge%0d", n), int'(dut.r_sq[0]), exp_sq(n));
            if (n == 1) check("ch_active_edge1", int'(bus.ch_active), 1);
            if (n == 17) bus.tone_period[7:0] = 8'd3;
        end
        check("sq1_idle", int'(dut.r_sq[1]), 0);

        // Disable and period change on the same edge: disable wins
        bus.ch_enable = 2'b00;
        bus.tone_period[7:0] = 8'd7;
        step();
        check("disable_wins_active", int'(bus.ch_active), 0);
        check("disable_wins_sq", int'(dut.r_sq[0]), 0);

        // Mixer table: hold voices high with period 255, sweep volume
        cur_en = -1;
        for (int v = 0; v < 10; v++) begin
            if (int'(vecs[v].en) != cur_en) begin
                bus.ch_enable = 2'b00;
                step();
                bus.ch_enable   = vecs[v].en;
                bus.tone_period = {8'd255, 8'd255};
                repeat (256) step();
                cur_en = int'(vecs[v].en);
            end
            bus.volume = vecs[v].vol;
            repeat (17) step();
            check($sformatf("duty_q_v%0d", v), int'(dut.r_duty_q), vecs[v].duty);
            count_high(c);
            check($sformatf("high_count_v%0d", v), c, vecs[v].duty);
        end

        // output_enable gating with voice 0 high, duty 8
        bus.output_enable = 1'b0;
        step();
        check("oe_off_out", int'(bus.square_wave_out), 0);
        count_high(c);
        check("oe_off_high_count", c, 0);
        p0 = int'(dut.r_pwm_cnt);
        repeat (3) step();
        check("oe_off_pwm_phase", int'(dut.r_pwm_cnt), (p0 + 3) % 16);
        pre = int'(dut.r_pwm_cnt);
        bus.output_enable = 1'b1;
        step();
        check("oe_on_out", int'(bus.square_wave_out), (pre < 8) ? 1 : 0);
        count_high(c);
        check("oe_on_high_count", c, 8);

        // Level change mid-carrier: duty_q holds until the carrier boundary
        wait_pwm(3);
        check("mid_duty_before", int'(dut.r_duty_q), 8);
        bus.ch_enable = 2'b00;
        step();
        check("mid_sq_dropped", int'(dut.r_sq[0]), 0);
        repeat (11) step();
        check("mid_pwm_at_15", int'(dut.r_pwm_cnt), 15);
        check("mid_duty_held", int'(dut.r_duty_q), 8);
        step();
        check("mid_duty_updated", int'(dut.r_duty_q), 0);

        // Asynchronous reset mid-tone, then restart at period 5
        bus.ch_enable = 2'b01;
        bus.tone_period[7:0] = 8'd40;
        bus.volume = 3'd7;
        repeat (41) step();
        repeat (17) step();
        wait_pwm(3);
        check("pre_reset_out", int'(bus.square_wave_out), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_out", int'(bus.square_wave_out), 0);
        check("async_reset_active", int'(bus.ch_active), 0);
        check("async_reset_duty", int'(dut.r_duty_q), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.tone_period[7:0] = 8'd5;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n == 1) check("restart_active", int'(bus.ch_active), 1);
            if (n == 5) check("restart_sq_edge5", int'(dut.r_sq[0]), 0);
            if (n == 6) check("restart_sq_edge6", int'(dut.r_sq[0]), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/poly_tone_mixer.md
# poly_tone_mixer

Multi-channel successor to the single-voice tone generator. Runs NUM_CH independent square-wave voices, each with its own half-period and enable. The voices are summed, scaled by a global volume, and rendered as one PWM bit for the board audio output. It sits between the music streamer(s) and aud_pwm, so chords and multi-track playback need no change to the audio path.

## Interface
- NUM_CH, 4: number of voices (1..16)
- PERIOD_W, 24: half-period width in clk cycles
- VOL_W, 3: global volume width; MAXV = 2^VOL_W-1
- PWM_W, 10: PWM carrier resolution; carrier period = 2^PWM_W cycles

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- output_enable  in  1  gates square_wave_out; internal state keeps running
- ch_enable  in  NUM_CH  per-voice enable
- tone_period  in  NUM_CH*PERIOD_W  voice i half-period at [i*PERIOD_W +: PERIOD_W]; 0 = silent
- volume  in  VOL_W  global volume; MAXV = full scale
- square_wave_out  out  1  registered PWM audio bit
- ch_active  out  NUM_CH  bit i = voice i shadow period nonzero

## Operation
- Per voice i, registers: cnt (PERIOD_W), shadow (PERIOD_W), sq (1).
- Disabled voice (ch_enable[i]=0): next edge cnt<=0, sq<=0, shadow<=0.
- Enabled, shadow==0: shadow<=tone_period[i], cnt<=0, sq<=0 (immediate load).
- Enabled, shadow!=0, cnt!=shadow-1: cnt<=cnt+1.
- Enabled, shadow!=0, cnt==shadow-1 (wrap): cnt<=0; shadow<=tone_period[i]; sq<=~sq if new period nonzero, else sq<=0.
- Period changes are glitch-free: a running voice takes a new period only at its wrap edge.
- ch_active[i] = (shadow!=0).
- Mixer: level = popcount(sq), width clog2(NUM_CH+1).
- STEP = floor(2^PWM_W / NUM_CH).
- raw = level*STEP, width PWM_W+1.
- duty = raw >> (MAXV - volume), so volume 0 divides by 2^MAXV.
- pwm_cnt: PWM_W-bit free-running counter that wraps 2^PWM_W-1 -> 0.
- duty_q (PWM_W+1 bits) <= duty only on the edge where pwm_cnt==2^PWM_W-1. Each carrier period therefore uses one stable duty.
- square_wave_out <= output_enable & (pwm_cnt < duty_q), using pre-edge values.
- All voices at full volume gives duty_q = 2^PWM_W when NUM_CH is a power of two; the output is then constantly high.

## Timing
- Reset (async assert, sync to clk on release): every cnt, shadow, sq, pwm_cnt and duty_q is 0; square_wave_out=0; ch_active=0.
- Voice start from idle:
  - Edge 1: shadow loads P.
  - Edges 2..P: cnt counts 0..P-1.
  - First toggle at edge P+1, then every P edges; square period = 2P cycles.
- Disable takes effect on the next edge regardless of phase.
- Simultaneous disable and period change on one voice: disable wins.
- Mixer-to-output latency:
  - sq change to duty_q: up to 2^PWM_W cycles (next carrier boundary).
  - duty_q to pin: 1 cycle.
- output_enable to pin: 1 cycle. It does not reset the counters.
- Reset asserted mid-operation clears all state immediately, with no partial carrier period.
- Voices are independent: no arbitration, all update in the same cycle.

## Test plan
Parameters for all tests: NUM_CH=2, PERIOD_W=8, PWM_W=4, VOL_W=3.
- Reset, then ch_enable=01, tone_period[0]=5 -> ch_active=01 after edge 1; sq0 rises at edge 6, falls at edge 11, period 10 cycles; sq1 stays 0.
- Voice 0 running at 5, change to 3 mid-cycle -> half-periods stay 5 until the next wrap, then become 3; no short or long pulse.
- Both voices enabled with sq both high, volume=7 -> duty_q=16, output high for all 16 carrier cycles; volume=6 -> duty_q=8, 8 high / 8 low per carrier.
- One voice high, volume=7 -> duty_q=8; change level mid-carrier -> duty_q updates only after pwm_cnt==15.
- output_enable=0 while playing -> square_wave_out=0 one edge later; re-enable resumes with pwm_cnt phase unchanged.
- Assert rst mid-tone, asynchronously between edges -> square_wave_out and ch_active drop to 0 immediately. Release -> voice restarts with first toggle at edge P+1.
